// File: rtl/conv1d_window_reader_if.sv
// Bus bundle for the 1-D convolution window reader: the RAM read port
// (request out, three taps back) and the output window stream.
interface conv1d_window_reader_if #(
  parameter int Bit_width = 16,
  parameter int RAM_Depth = 256
);
  localparam int PosW = $clog2(RAM_Depth);

  logic                        rd_en;
  logic [2:0]                  rd_depth;
  logic [PosW-1:0]             rd_width;
  logic signed [Bit_width-1:0] rd_tap0;
  logic signed [Bit_width-1:0] rd_tap1;
  logic signed [Bit_width-1:0] rd_tap2;

  logic                        out_valid;
  logic                        out_ready;
  logic signed [Bit_width-1:0] out_tap0;
  logic signed [Bit_width-1:0] out_tap1;
  logic signed [Bit_width-1:0] out_tap2;
  logic [2:0]                  out_ch;
  logic [PosW-1:0]             out_pos;
  logic                        out_last_ch;
  logic                        out_last;

  // reader side
  modport master (
    output rd_en, rd_depth, rd_width,
    input  rd_tap0, rd_tap1, rd_tap2,
    output out_valid, out_tap0, out_tap1, out_tap2,
    output out_ch, out_pos, out_last_ch, out_last,
    input  out_ready
  );

  // RAM / consumer side
  modport slave (
    input  rd_en, rd_depth, rd_width,
    output rd_tap0, rd_tap1, rd_tap2,
    input  out_valid, out_tap0, out_tap1, out_tap2,
    input  out_ch, out_pos, out_last_ch, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv1d_window_reader.sv
// Scans a channel x position sample RAM position-major and streams one
// three-tap window per (position, channel) through a 2-entry output FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; config latched on a legal start
// RUN   | issuing read requests as buffer room and the write port allow
// DRAIN | all requests issued; waiting for in-flight read and FIFO to empty
// DONE  | one-cycle completion pulse
module conv1d_window_reader #(
  parameter int Bit_width = 16,
  parameter int RAM_Depth = 256
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [3:0] num_ch,
  input  logic [8:0] num_pos,
  input  logic       wr_busy,
  output logic       busy,
  output logic       done,
  conv1d_window_reader_if.master bus
);
  localparam int PosW = $clog2(RAM_Depth);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic signed [Bit_width-1:0] tap0;
    logic signed [Bit_width-1:0] tap1;
    logic signed [Bit_width-1:0] tap2;
    logic [2:0]                  ch;
    logic [PosW-1:0]             pos;
    logic                        last_ch;
    logic                        last;
  } entry_t;

  state_t          state, state_nxt;
  logic [2:0]      last_ch_q;
  logic [PosW-1:0] last_pos_q;
  logic [2:0]      iss_ch;
  logic [PosW-1:0] iss_pos;

  logic            rd_en_q;
  logic [2:0]      rd_depth_q;
  logic [PosW-1:0] rd_width_q;
  logic            tag_last_ch, tag_last_pos, tag_last;

  entry_t          fifo_mem [2];
  entry_t          new_entry;
  entry_t          head;
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;

  logic            cfg_ok;
  logic            push, pop;
  logic [2:0]      free_slots;
  logic            issue, issue_final;
  logic            iss_last_ch, iss_last_pos;

  assign cfg_ok = (num_ch != 4'd0) && (num_ch <= 4'd8) &&
                  (num_pos != 9'd0) && (num_pos <= 9'(RAM_Depth));

  assign push = rd_en_q;
  assign pop  = bus.out_valid & bus.out_ready;

  // Room left once this cycle's pop is taken into account; a request may
  // only go out if its data still fits after the read already in flight.
  assign free_slots   = 3'd2 - {1'b0, count} + {2'b00, pop};
  assign iss_last_ch  = (iss_ch == last_ch_q);
  assign iss_last_pos = (iss_pos == last_pos_q);
  assign issue        = (state == RUN) && !wr_busy && (free_slots > {2'b00, rd_en_q});
  assign issue_final  = issue && iss_last_ch && iss_last_pos;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = cfg_ok ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (issue_final) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!rd_en_q && ((count == 2'd0) || ((count == 2'd1) && pop))) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch and scan position counters (channel inner, position outer)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_ch_q  <= '0;
      last_pos_q <= '0;
      iss_ch     <= '0;
      iss_pos    <= '0;
    end else if ((state == IDLE) && start && cfg_ok) begin
      last_ch_q  <= 3'(num_ch - 4'd1);
      last_pos_q <= PosW'(num_pos - 9'd1);
      iss_ch     <= '0;
      iss_pos    <= '0;
    end else if (issue) begin
      if (iss_last_ch) begin
        iss_ch  <= '0;
        iss_pos <= iss_pos + 1'b1;
      end else begin
        iss_ch  <= iss_ch + 1'b1;
      end
    end
  end

  // Registered read request; the tags ride along until the taps come back
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_en_q      <= 1'b0;
      rd_depth_q   <= '0;
      rd_width_q   <= '0;
      tag_last_ch  <= 1'b0;
      tag_last_pos <= 1'b0;
      tag_last     <= 1'b0;
    end else begin
      rd_en_q <= issue;
      if (issue) begin
        rd_depth_q   <= iss_ch;
        rd_width_q   <= iss_pos;
        tag_last_ch  <= iss_last_ch;
        tag_last_pos <= iss_last_pos;
        tag_last     <= iss_last_ch && iss_last_pos;
      end
    end
  end

  // Incoming window; the right edge pads tap2 with zero
  always_comb begin
    new_entry         = '0;
    new_entry.tap0    = bus.rd_tap0;
    new_entry.tap1    = bus.rd_tap1;
    new_entry.tap2    = tag_last_pos ? '0 : bus.rd_tap2;
    new_entry.ch      = rd_depth_q;
    new_entry.pos     = rd_width_q;
    new_entry.last_ch = tag_last_ch;
    new_entry.last    = tag_last;
  end

  // Two-entry output FIFO; issue gating guarantees a push never overflows
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= new_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = fifo_mem[rd_ptr];

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_depth    = rd_depth_q;
  assign bus.rd_width    = rd_width_q;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_tap0    = head.tap0;
  assign bus.out_tap1    = head.tap1;
  assign bus.out_tap2    = head.tap2;
  assign bus.out_ch      = head.ch;
  assign bus.out_pos     = head.pos;
  assign bus.out_last_ch = head.last_ch;
  assign bus.out_last    = head.last;
endmodule
